// File: rtl/stacktrbuf_tracker_if.sv
// Executor/debug-side bundle of the stack trace buffer write-side tracker.
// The master drives events and frame index; the slave returns write port and status.
interface stacktrbuf_tracker_if #(
    parameter int ARCH  = 64,
    parameter int ABITS = 5
);
    logic                i_e_valid;
    logic [ARCH-1:0]     i_e_pc;
    logic [ARCH-1:0]     i_e_npc;
    logic                i_e_call;
    logic                i_e_ret;
    logic                i_clr;
    logic [ABITS-1:0]    i_dbg_idx;
    logic                o_we;
    logic [ABITS-1:0]    o_waddr;
    logic [2*ARCH-1:0]   o_wdata;
    logic [ABITS-1:0]    o_raddr;
    logic [ABITS:0]      o_depth;
    logic                o_overflow;
    logic                o_underflow;

    modport master (
        output i_e_valid, i_e_pc, i_e_npc, i_e_call, i_e_ret, i_clr, i_dbg_idx,
        input  o_we, o_waddr, o_wdata, o_raddr, o_depth, o_overflow, o_underflow
    );

    modport slave (
        input  i_e_valid, i_e_pc, i_e_npc, i_e_call, i_e_ret, i_clr, i_dbg_idx,
        output o_we, o_waddr, o_wdata, o_raddr, o_depth, o_overflow, o_underflow
    );
endinterface

// File: rtl/stacktrbuf_tracker.sv
// Stack trace buffer write side: call/return tracking, circular write pointer,
// saturating depth and logical-to-physical frame address translation.
module stacktrbuf_tracker #(
    parameter int ARCH  = 64,
    parameter int SIZE  = 32,
    parameter int ABITS = 5
) (
    input logic                 i_clk,
    input logic                 i_rst,
    stacktrbuf_tracker_if.slave bus
);
    localparam logic [ABITS:0]   FULL  = (ABITS+1)'(SIZE);
    localparam logic [ABITS-1:0] AONE  = ABITS'(1);
    localparam logic [ABITS:0]   DONE  = (ABITS+1)'(1);

    logic [ABITS-1:0]  wptr, wptr_n;
    logic [ABITS:0]    depth, depth_n;
    logic              we, we_n;
    logic [ABITS-1:0]  waddr, waddr_n;
    logic [2*ARCH-1:0] wdata, wdata_n;
    logic              ovf, ovf_n;
    logic              unf, unf_n;
    logic              call, ret, empty, full;

    assign call  = bus.i_e_valid & bus.i_e_call;
    assign ret   = bus.i_e_valid & bus.i_e_ret;
    assign empty = (depth == '0);
    assign full  = (depth == FULL);

    always_comb begin
        wptr_n  = wptr;
        depth_n = depth;
        we_n    = 1'b0;
        waddr_n = waddr;
        wdata_n = wdata;
        ovf_n   = ovf;
        unf_n   = unf;
        if (bus.i_clr) begin
            wptr_n  = '0;
            depth_n = '0;
            ovf_n   = 1'b0;
            unf_n   = 1'b0;
        end else if (call && ret && !empty) begin
            // pop-then-push: replace the newest frame in place
            we_n    = 1'b1;
            waddr_n = wptr - AONE;
            wdata_n = {bus.i_e_pc, bus.i_e_npc};
        end else if (call) begin
            we_n    = 1'b1;
            waddr_n = wptr;
            wdata_n = {bus.i_e_pc, bus.i_e_npc};
            wptr_n  = wptr + AONE;
            if (full) ovf_n = 1'b1;
            else      depth_n = depth + DONE;
            if (ret) unf_n = 1'b1;
        end else if (ret) begin
            if (empty) begin
                unf_n = 1'b1;
            end else begin
                wptr_n  = wptr - AONE;
                depth_n = depth - DONE;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wptr  <= '0;
            depth <= '0;
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            wptr  <= wptr_n;
            depth <= depth_n;
            we    <= we_n;
            waddr <= waddr_n;
            wdata <= wdata_n;
            ovf   <= ovf_n;
            unf   <= unf_n;
        end
    end

    assign bus.o_we        = we;
    assign bus.o_waddr     = waddr;
    assign bus.o_wdata     = wdata;
    assign bus.o_depth     = depth;
    assign bus.o_overflow  = ovf;
    assign bus.o_underflow = unf;
    assign bus.o_raddr     = wptr - AONE - bus.i_dbg_idx;
endmodule

// File: tb/tb_stacktrbuf_tracker.sv
// Directed bench for stacktrbuf_tracker with a frame-level reference model
// and hand-computed literal expectations.
module tb_stacktrbuf_tracker;
    localparam int ARCH  = 64;
    localparam int SIZE  = 32;
    localparam int ABITS = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   cmp_en = 1'b0;

    always #5 clk = ~clk;

    stacktrbuf_tracker_if #(.ARCH(ARCH), .ABITS(ABITS)) bus ();

    stacktrbuf_tracker #(.ARCH(ARCH), .SIZE(SIZE), .ABITS(ABITS)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // Reference: newest frame sits at physical slot (top-1); depth counts live frames.
    int          m_top   = 0;
    int          m_depth = 0;
    bit          m_ovf   = 0;
    bit          m_unf   = 0;
    bit          m_we    = 0;
    int          m_waddr = 0;
    logic [127:0] m_wdata = '0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_top = 0; m_depth = 0; m_ovf = 0; m_unf = 0;
            m_we = 0; m_waddr = 0; m_wdata = '0;
        end else begin
            m_we = 0;
            if (bus.i_clr) begin
                m_top = 0; m_depth = 0; m_ovf = 0; m_unf = 0;
            end else if (bus.i_e_valid) begin
                if (bus.i_e_call && bus.i_e_ret && m_depth > 0) begin
                    m_we = 1;
                    m_waddr = (m_top + SIZE - 1) % SIZE;
                    m_wdata = {bus.i_e_pc, bus.i_e_npc};
                end else if (bus.i_e_call) begin
                    if (bus.i_e_ret) m_unf = 1;
                    if (m_depth == SIZE) m_ovf = 1;
                    m_we = 1;
                    m_waddr = m_top;
                    m_wdata = {bus.i_e_pc, bus.i_e_npc};
                    m_top = (m_top + 1) % SIZE;
                    m_depth = (m_depth < SIZE) ? m_depth + 1 : SIZE;
                end else if (bus.i_e_ret) begin
                    if (m_depth == 0) m_unf = 1;
                    else begin
                        m_top = (m_top + SIZE - 1) % SIZE;
                        m_depth = m_depth - 1;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_we", 128'(bus.o_we), 128'(m_we));
            if (m_we) begin
                chk("m_waddr", 128'(bus.o_waddr), 128'(m_waddr));
                chk("m_wdata", bus.o_wdata, m_wdata);
            end
            chk("m_depth", 128'(bus.o_depth), 128'(m_depth));
            chk("m_ovf", 128'(bus.o_overflow), 128'(m_ovf));
            chk("m_unf", 128'(bus.o_underflow), 128'(m_unf));
            chk("m_raddr", 128'(bus.o_raddr),
                128'((m_top + 2*SIZE - 1 - int'(bus.i_dbg_idx)) % SIZE));
        end
    end

    // Present one event for a cycle; on return its effect is visible on the outputs.
    task automatic op(input bit v, input bit c, input bit r, input bit clr,
                      input logic [63:0] pc, input logic [63:0] npc);
        @(posedge clk); #1;
        bus.i_e_valid = v; bus.i_e_call = c; bus.i_e_ret = r;
        bus.i_clr = clr; bus.i_e_pc = pc; bus.i_e_npc = npc;
        @(posedge clk); #1;
        bus.i_e_valid = 0; bus.i_e_call = 0; bus.i_e_ret = 0; bus.i_clr = 0;
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst = 1;
        @(negedge clk); #1;
        rst = 0;
    endtask

    initial begin
        bus.i_e_valid = 0; bus.i_e_call = 0; bus.i_e_ret = 0; bus.i_clr = 0;
        bus.i_e_pc = '0; bus.i_e_npc = '0; bus.i_dbg_idx = '0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        cmp_en = 1;
        chk("rst_we", 128'(bus.o_we), 128'(0));
        chk("rst_waddr", 128'(bus.o_waddr), 128'(0));
        chk("rst_wdata", bus.o_wdata, 128'(0));
        chk("rst_depth", 128'(bus.o_depth), 128'(0));
        chk("rst_flags", 128'({bus.o_overflow, bus.o_underflow}), 128'(0));

        op(1, 1, 0, 0, 64'h1000, 64'h1100);
        chk("c1_we", 128'(bus.o_we), 128'(1));
        chk("c1_waddr", 128'(bus.o_waddr), 128'(0));
        chk("c1_wdata", bus.o_wdata, {64'h1000, 64'h1100});
        op(1, 1, 0, 0, 64'h2000, 64'h2100);
        chk("c2_waddr", 128'(bus.o_waddr), 128'(1));
        op(1, 1, 0, 0, 64'h3000, 64'h3100);
        chk("c3_waddr", 128'(bus.o_waddr), 128'(2));
        chk("c3_wdata", bus.o_wdata, {64'h3000, 64'h3100});
        chk("c3_depth", 128'(bus.o_depth), 128'(3));
        bus.i_dbg_idx = 0; #1;
        chk("raddr_i0", 128'(bus.o_raddr), 128'(2));
        bus.i_dbg_idx = 2; #1;
        chk("raddr_i2", 128'(bus.o_raddr), 128'(0));
        bus.i_dbg_idx = 0;

        op(1, 0, 1, 0, 64'h0, 64'h0);
        chk("r1_we", 128'(bus.o_we), 128'(0));
        op(1, 0, 1, 0, 64'h0, 64'h0);
        chk("r2_depth", 128'(bus.o_depth), 128'(1));
        op(1, 1, 0, 0, 64'h4000, 64'h4100);
        chk("c4_waddr", 128'(bus.o_waddr), 128'(1));
        op(0, 1, 1, 0, 64'h9000, 64'h9100);
        chk("inval_we", 128'(bus.o_we), 128'(0));
        chk("inval_depth", 128'(bus.o_depth), 128'(2));

        do_reset();
        for (int i = 0; i < 33; i++)
            op(1, 1, 0, 0, 64'(i * 16), 64'(i * 16 + 4));
        chk("ovf_depth", 128'(bus.o_depth), 128'(32));
        chk("ovf_flag", 128'(bus.o_overflow), 128'(1));
        chk("ovf_waddr", 128'(bus.o_waddr), 128'(0));
        bus.i_dbg_idx = 0; #1;
        chk("ovf_raddr", 128'(bus.o_raddr), 128'(0));

        do_reset();
        op(1, 0, 1, 0, 64'h0, 64'h0);
        chk("unf_flag", 128'(bus.o_underflow), 128'(1));
        chk("unf_we", 128'(bus.o_we), 128'(0));
        chk("unf_depth", 128'(bus.o_depth), 128'(0));
        op(1, 1, 0, 0, 64'h6000, 64'h6100);
        chk("unf_c_waddr", 128'(bus.o_waddr), 128'(0));
        chk("unf_c_depth", 128'(bus.o_depth), 128'(1));

        do_reset();
        op(1, 1, 0, 0, 64'h1000, 64'h1100);
        op(1, 1, 0, 0, 64'h2000, 64'h2100);
        op(1, 1, 1, 0, 64'h5000, 64'h5100);
        chk("cr_we", 128'(bus.o_we), 128'(1));
        chk("cr_waddr", 128'(bus.o_waddr), 128'(1));
        chk("cr_depth", 128'(bus.o_depth), 128'(2));
        chk("cr_wdata", bus.o_wdata, {64'h5000, 64'h5100});
        do_reset();
        op(1, 1, 1, 0, 64'h5000, 64'h5100);
        chk("cr0_waddr", 128'(bus.o_waddr), 128'(0));
        chk("cr0_depth", 128'(bus.o_depth), 128'(1));
        chk("cr0_unf", 128'(bus.o_underflow), 128'(1));

        do_reset();
        op(1, 0, 1, 0, 64'h0, 64'h0);
        for (int i = 0; i < 5; i++)
            op(1, 1, 0, 0, 64'h7000 + 64'(i), 64'h7100 + 64'(i));
        op(1, 1, 0, 1, 64'h8000, 64'h8100);
        chk("clr_we", 128'(bus.o_we), 128'(0));
        chk("clr_depth", 128'(bus.o_depth), 128'(0));
        chk("clr_flags", 128'({bus.o_overflow, bus.o_underflow}), 128'(0));

        op(1, 1, 0, 0, 64'h1000, 64'h1100);
        op(1, 1, 0, 0, 64'h2000, 64'h2100);
        @(posedge clk); #1;
        bus.i_e_valid = 1; bus.i_e_call = 1;
        bus.i_e_pc = 64'hA000; bus.i_e_npc = 64'hA100;
        @(posedge clk); #1;
        bus.i_e_valid = 0; bus.i_e_call = 0;
        chk("mid_we_pre", 128'(bus.o_we), 128'(1));
        rst = 1; #1;
        chk("mid_we", 128'(bus.o_we), 128'(0));
        chk("mid_depth", 128'(bus.o_depth), 128'(0));
        chk("mid_waddr", 128'(bus.o_waddr), 128'(0));
        chk("mid_wdata", bus.o_wdata, 128'(0));
        @(negedge clk); #1;
        rst = 0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
